// File: rtl/rob_retire.sv
// 2-wide in-order ROB commit stage: pops done heads, updates arch map / free list, flushes on mispredict, stops on halt.
// Optional stats counters (stat_retired, stat_mispred) are built when RETIRE_STATS_EN is defined.
module rob_retire #(
  parameter int PREG_IDX     = 6,
  parameter int AREG_IDX     = 5,
  parameter int ZERO_REG     = 31,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                head1_valid,
  input  logic                head1_done,
  input  logic                head1_mispred,
  input  logic                head1_halt,
  input  logic [AREG_IDX-1:0] head1_areg,
  input  logic [PREG_IDX-1:0] head1_preg,
  input  logic [PREG_IDX-1:0] head1_old_preg,
  input  logic [63:0]         head1_target,
  input  logic                head2_valid,
  input  logic                head2_done,
  input  logic                head2_mispred,
  input  logic                head2_halt,
  input  logic [AREG_IDX-1:0] head2_areg,
  input  logic [PREG_IDX-1:0] head2_preg,
  input  logic [PREG_IDX-1:0] head2_old_preg,
  input  logic [63:0]         head2_target,
  output logic                rd1,
  output logic                rd2,
  output logic                amt1_wr_en,
  output logic [AREG_IDX-1:0] amt1_areg,
  output logic [PREG_IDX-1:0] amt1_preg,
  output logic                amt2_wr_en,
  output logic [AREG_IDX-1:0] amt2_areg,
  output logic [PREG_IDX-1:0] amt2_preg,
  output logic                fl1_en,
  output logic [PREG_IDX-1:0] fl1_preg,
  output logic                fl2_en,
  output logic [PREG_IDX-1:0] fl2_preg,
  output logic                flush,
  output logic [63:0]         redirect_pc,
  output logic                halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]         stat_retired,
  output logic [31:0]         stat_mispred
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        ret1, ret2, any_halt, any_mis, wr1, wr2, enter_flush;
  logic [63:0] mis_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == FLUSH && state_nxt == FLUSH) ? cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (any_halt)     state_nxt = HALTED;
        else if (any_mis) state_nxt = FLUSH;
      end
      FLUSH:   if (cnt == 3'(FLUSH_CYCLES - 1)) state_nxt = RUN;
      default: state_nxt = HALTED;
    endcase
  end

  // Slot 2 may only retire behind a plain slot 1, so order is preserved.
  always_comb begin
    ret1        = (state == RUN) & head1_valid & head1_done;
    ret2        = ret1 & head2_valid & head2_done & ~head1_mispred & ~head1_halt;
    any_halt    = (ret1 & head1_halt) | (ret2 & head2_halt);
    any_mis     = (ret1 & head1_mispred) | (ret2 & head2_mispred);
    mis_target  = (ret2 & head2_mispred) ? head2_target : head1_target;
    enter_flush = (state == RUN) & (state_nxt == FLUSH);
    wr1         = ret1 & (head1_areg != AREG_IDX'(ZERO_REG));
    wr2         = ret2 & (head2_areg != AREG_IDX'(ZERO_REG));
    rd1         = ret1;
    rd2         = ret2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amt1_wr_en  <= 1'b0;
      amt1_areg   <= '0;
      amt1_preg   <= '0;
      amt2_wr_en  <= 1'b0;
      amt2_areg   <= '0;
      amt2_preg   <= '0;
      fl1_en      <= 1'b0;
      fl1_preg    <= '0;
      fl2_en      <= 1'b0;
      fl2_preg    <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      halted      <= 1'b0;
    end else begin
      amt1_wr_en <= wr1;
      fl1_en     <= wr1;
      amt2_wr_en <= wr2;
      fl2_en     <= wr2;
      if (wr1) begin
        amt1_areg <= head1_areg;
        amt1_preg <= head1_preg;
        fl1_preg  <= head1_old_preg;
      end
      if (wr2) begin
        amt2_areg <= head2_areg;
        amt2_preg <= head2_preg;
        fl2_preg  <= head2_old_preg;
      end
      flush  <= (state_nxt == FLUSH);
      halted <= (state_nxt == HALTED);
      if (enter_flush) redirect_pc <= mis_target;
    end
  end

`ifdef RETIRE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_retired <= '0;
      stat_mispred <= '0;
    end else begin
      stat_retired <= stat_retired + 64'(ret1) + 64'(ret2);
      stat_mispred <= stat_mispred + 32'(enter_flush);
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Scoreboard bench for rob_retire: expected map/free-list updates queued at pop time, compared one cycle later.
module tb_rob_retire;

  typedef struct packed {
    logic        valid, done, mispred, halt;
    logic [4:0]  areg;
    logic [5:0]  preg, old;
    logic [63:0] target;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        head1_valid, head1_done, head1_mispred, head1_halt;
  logic [4:0]  head1_areg;
  logic [5:0]  head1_preg, head1_old_preg;
  logic [63:0] head1_target;
  logic        head2_valid, head2_done, head2_mispred, head2_halt;
  logic [4:0]  head2_areg;
  logic [5:0]  head2_preg, head2_old_preg;
  logic [63:0] head2_target;
  logic        rd1, rd2, amt1_wr_en, amt2_wr_en, fl1_en, fl2_en, flush, halted;
  logic [4:0]  amt1_areg, amt2_areg;
  logic [5:0]  amt1_preg, amt2_preg, fl1_preg, fl2_preg;
  logic [63:0] redirect_pc;
`ifdef RETIRE_STATS_EN
  logic [63:0] stat_retired;
  logic [31:0] stat_mispred;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [37:0] sb_q[$];
  longint      exp_retired = 0;
  int          exp_mispred = 0;

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .reset(reset),
    .head1_valid(head1_valid), .head1_done(head1_done), .head1_mispred(head1_mispred),
    .head1_halt(head1_halt), .head1_areg(head1_areg), .head1_preg(head1_preg),
    .head1_old_preg(head1_old_preg), .head1_target(head1_target),
    .head2_valid(head2_valid), .head2_done(head2_done), .head2_mispred(head2_mispred),
    .head2_halt(head2_halt), .head2_areg(head2_areg), .head2_preg(head2_preg),
    .head2_old_preg(head2_old_preg), .head2_target(head2_target),
    .rd1(rd1), .rd2(rd2),
    .amt1_wr_en(amt1_wr_en), .amt1_areg(amt1_areg), .amt1_preg(amt1_preg),
    .amt2_wr_en(amt2_wr_en), .amt2_areg(amt2_areg), .amt2_preg(amt2_preg),
    .fl1_en(fl1_en), .fl1_preg(fl1_preg), .fl2_en(fl2_en), .fl2_preg(fl2_preg),
    .flush(flush), .redirect_pc(redirect_pc), .halted(halted)
`ifdef RETIRE_STATS_EN
    , .stat_retired(stat_retired), .stat_mispred(stat_mispred)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic v, d, m, h, input logic [4:0] a,
                              input logic [5:0] p, o, input logic [63:0] t);
    ent_t e;
    e.valid = v; e.done = d; e.mispred = m; e.halt = h;
    e.areg = a; e.preg = p; e.old = o; e.target = t;
    return e;
  endfunction

  // Observed slot fields are masked by their own enables so stale data never matters.
  task automatic monitor();
    logic [37:0] obs;
    obs = {amt1_wr_en, fl1_en, amt1_wr_en ? amt1_areg : 5'd0, amt1_wr_en ? amt1_preg : 6'd0,
           fl1_en ? fl1_preg : 6'd0,
           amt2_wr_en, fl2_en, amt2_wr_en ? amt2_areg : 5'd0, amt2_wr_en ? amt2_preg : 6'd0,
           fl2_en ? fl2_preg : 6'd0};
    if (amt1_wr_en | fl1_en | amt2_wr_en | fl2_en) begin
      if (sb_q.size() == 0) check("unexpected_amt_fl", 64'(obs), 64'd0);
      else check("amt_fl", 64'(obs), 64'(sb_q.pop_front()));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive(input string tag, input ent_t e1, input ent_t e2, input logic er1, input logic er2);
    logic w1, w2;
    head1_valid = e1.valid; head1_done = e1.done; head1_mispred = e1.mispred; head1_halt = e1.halt;
    head1_areg = e1.areg; head1_preg = e1.preg; head1_old_preg = e1.old; head1_target = e1.target;
    head2_valid = e2.valid; head2_done = e2.done; head2_mispred = e2.mispred; head2_halt = e2.halt;
    head2_areg = e2.areg; head2_preg = e2.preg; head2_old_preg = e2.old; head2_target = e2.target;
    #1;
    check({tag, "_rd1"}, 64'(rd1), 64'(er1));
    check({tag, "_rd2"}, 64'(rd2), 64'(er2));
    w1 = er1 && (e1.areg != 5'd31);
    w2 = er2 && (e2.areg != 5'd31);
    if (w1 || w2)
      sb_q.push_back({w1, w1, w1 ? e1.areg : 5'd0, w1 ? e1.preg : 6'd0, w1 ? e1.old : 6'd0,
                      w2, w2, w2 ? e2.areg : 5'd0, w2 ? e2.preg : 6'd0, w2 ? e2.old : 6'd0});
    exp_retired += longint'(er1) + longint'(er2);
    cycle();
  endtask

  task automatic check_stats(input string tag);
`ifdef RETIRE_STATS_EN
    check({tag, "_stat_retired"}, stat_retired, 64'(exp_retired));
    check({tag, "_stat_mispred"}, 64'(stat_mispred), 64'(exp_mispred));
`else
    n_checks += 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive("rst", mk(0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0), 1'b0, 1'b0);
    exp_retired = 0;
    exp_mispred = 0;
    reset = 1'b0;
  endtask

  ent_t idle, n1, n2;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0);
    do_reset();
    check("rst_amt1", 64'(amt1_wr_en), 64'd0);
    check("rst_fl2", 64'(fl2_en), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_redirect", redirect_pc, 64'd0);
    check_stats("rst");

    drive("dual", mk(1,1,0,0,3,40,10,0), mk(1,1,0,0,4,41,11,0), 1'b1, 1'b1);
    drive("h1_not_done", mk(1,0,0,0,5,42,12,0), mk(1,1,0,0,6,43,13,0), 1'b0, 1'b0);
    drive("h1_done", mk(1,1,0,0,5,42,12,0), mk(1,1,0,0,6,43,13,0), 1'b1, 1'b1);
    drive("same_areg", mk(1,1,0,0,7,20,14,0), mk(1,1,0,0,7,21,20,0), 1'b1, 1'b1);
    drive("zero_reg", mk(1,1,0,0,31,22,15,0), idle, 1'b1, 1'b0);
    check("zero_reg_wr", 64'(amt1_wr_en), 64'd0);
    drive("empty", mk(0,1,0,0,8,23,16,0), mk(0,1,0,0,9,24,17,0), 1'b0, 1'b0);

    // Head-1 mispredict: branch retires alone, then two flush cycles.
    n1 = mk(1,1,0,0,10,25,18,0);
    n2 = mk(1,1,0,0,11,26,19,0);
    drive("mis1", mk(1,1,1,0,8,27,21,64'h1000), mk(1,1,0,0,9,28,22,0), 1'b1, 1'b0);
    exp_mispred++;
    check("mis1_flush_c1", 64'(flush), 64'd1);
    check("mis1_pc_c1", redirect_pc, 64'h1000);
    drive("mis1_fl1", n1, n2, 1'b0, 1'b0);
    check("mis1_flush_c2", 64'(flush), 64'd1);
    check("mis1_pc_c2", redirect_pc, 64'h1000);
    drive("mis1_fl2", n1, n2, 1'b0, 1'b0);
    check("mis1_flush_end", 64'(flush), 64'd0);
    drive("mis1_resume", n1, n2, 1'b1, 1'b1);

    drive("mis2", mk(1,1,0,0,12,29,23,0), mk(1,1,1,0,13,30,24,64'h2000), 1'b1, 1'b1);
    exp_mispred++;
    check("mis2_pc", redirect_pc, 64'h2000);
    drive("mis2_fl1", n1, n2, 1'b0, 1'b0);
    drive("mis2_fl2", n1, n2, 1'b0, 1'b0);
    check_stats("mid");

    drive("mis3", mk(1,1,1,0,14,31,25,64'h3000), idle, 1'b1, 1'b0);
    check("mis3_flush", 64'(flush), 64'd1);
    do_reset();
    check("rst_in_flush", 64'(flush), 64'd0);
    check_stats("rst_in_flush");
    drive("rst_resume", n1, n2, 1'b1, 1'b1);

    drive("halt2", mk(1,1,0,0,15,32,26,0), mk(1,1,0,1,16,33,27,0), 1'b1, 1'b1);
    check("halt2_halted", 64'(halted), 64'd1);
    drive("halted_a", n1, n2, 1'b0, 1'b0);
    drive("halted_b", mk(1,1,1,0,17,34,28,64'h4000), n2, 1'b0, 1'b0);
    check("halted_sticky", 64'(halted), 64'd1);
    check("halted_noflush", 64'(flush), 64'd0);
    do_reset();
    check("rst_halted_clr", 64'(halted), 64'd0);

    drive("halt_mis", mk(1,1,1,1,18,35,29,64'h5000), n2, 1'b1, 1'b0);
    check("halt_mis_halted", 64'(halted), 64'd1);
    check("halt_mis_flush", 64'(flush), 64'd0);
    do_reset();
    drive("final", n1, n2, 1'b1, 1'b1);
    check_stats("final");
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
